ft_txfifo_arbiter: RTL and testbench

- Packet-granular round-robin arbiter sharing the single TX FIFO write port (sys_clk side of the FT245 master) between N_REQ independent byte-stream sources: test-pattern generator, command responder, status reporter.
- Grant is held for a whole packet (req_last), with a forced release after MAX_PKT_LEN words for fairness.
- Output write stage is registered and stalls on txfifo_full.

---
 rtl/ft_txfifo_arbiter.sv | 165 ++++++++++++++++
 tb/tb_ft_txfifo_arbiter.sv | 258 +++++++++++++++++++++++++
 2 files changed

// File: rtl/ft_txfifo_arbiter.sv
// Packet-granular round-robin arbiter feeding the FT245 TX FIFO write port.
// Define FT_TXARB_HDR_EN to prefix each grant with a {4'hA, grant_id} header word.
module ft_txfifo_arbiter #(
  parameter int unsigned DATA_W      = 8,
  parameter int unsigned N_REQ       = 3,
  parameter int unsigned MAX_PKT_LEN = 512
) (
  input  logic                      sys_clk,
  input  logic                      sys_rst,
  input  logic [N_REQ-1:0]          req_valid,
  input  logic [N_REQ*DATA_W-1:0]   req_data,
  input  logic [N_REQ-1:0]          req_last,
  output logic [N_REQ-1:0]          req_ready,
  output logic [DATA_W-1:0]         txfifo_data,
  output logic                      txfifo_wr,
  input  logic                      txfifo_full,
  output logic [3:0]                grant_id,
  output logic                      busy,
  output logic                      trunc_pulse
);

  localparam int unsigned ID_W  = 4;
  localparam int unsigned CNT_W = 16;
  localparam int unsigned SH_W  = 5;

  typedef enum logic [1:0] {ST_IDLE, ST_HDR, ST_PKT} state_t;

  state_t              state_q, state_d;
  logic [ID_W-1:0]     grant_q, grant_d;
  logic [ID_W-1:0]     last_q, last_d;
  logic [CNT_W-1:0]    cnt_q, cnt_d;
  logic                wr_q, wr_d;
  logic [DATA_W-1:0]   data_q, data_d;
  logic                trunc_q, trunc_d;

  logic                out_free;
  logic [N_REQ-1:0]    gnt_oh;
  logic                g_valid;
  logic                g_last;
  logic [DATA_W-1:0]   g_data;
  logic                hs;
  logic                load;
  logic [DATA_W-1:0]   load_data;

  logic [2*N_REQ-1:0]  dbl_valid;
  logic [N_REQ-1:0]    rot_valid;
  logic [SH_W-1:0]     sum;
  logic                found;
  logic [ID_W-1:0]     pick_id;

  assign out_free = !wr_q || !txfifo_full;

  // Round-robin pick: rotate so bit 0 is last_grant+1, take the first set bit.
  always_comb begin
    dbl_valid = {req_valid, req_valid};
    rot_valid = N_REQ'(dbl_valid >> (SH_W'(last_q) + SH_W'(1)));
    found     = 1'b0;
    pick_id   = '0;
    sum       = '0;
    for (int unsigned j = 0; j < N_REQ; j++) begin
      if (!found && rot_valid[j]) begin
        found = 1'b1;
        sum   = SH_W'(last_q) + SH_W'(j + 1);
        if (sum >= SH_W'(N_REQ)) sum = sum - SH_W'(N_REQ);
        pick_id = ID_W'(sum);
      end
    end
  end

  // Mux the granted requester's valid/last/data.
  always_comb begin
    gnt_oh  = '0;
    g_valid = 1'b0;
    g_last  = 1'b0;
    g_data  = '0;
    for (int unsigned i = 0; i < N_REQ; i++) begin
      gnt_oh[i] = (grant_q == ID_W'(i));
      if (gnt_oh[i]) begin
        g_valid = req_valid[i];
        g_last  = req_last[i];
        g_data  = req_data[i*DATA_W +: DATA_W];
      end
    end
  end

  assign req_ready = (state_q == ST_PKT && out_free) ? gnt_oh : '0;
  assign hs        = (state_q == ST_PKT) && out_free && g_valid;

  always_comb begin
    state_d   = state_q;
    grant_d   = grant_q;
    last_d    = last_q;
    cnt_d     = cnt_q;
    trunc_d   = 1'b0;
    load      = 1'b0;
    load_data = g_data;
    case (state_q)
      ST_IDLE: begin
        if (found) begin
          grant_d = pick_id;
          cnt_d   = '0;
`ifdef FT_TXARB_HDR_EN
          state_d = ST_HDR;
`else
          state_d = ST_PKT;
`endif
        end
      end
`ifdef FT_TXARB_HDR_EN
      ST_HDR: begin
        if (out_free) begin
          load      = 1'b1;
          load_data = DATA_W'({4'hA, grant_q});
          state_d   = ST_PKT;
        end
      end
`endif
      ST_PKT: begin
        if (hs) begin
          load  = 1'b1;
          cnt_d = cnt_q + CNT_W'(1);
          if (g_last) begin
            last_d  = grant_q;
            state_d = ST_IDLE;
          end else if (cnt_q + CNT_W'(1) == CNT_W'(MAX_PKT_LEN)) begin
            last_d  = grant_q;
            trunc_d = 1'b1;
            state_d = ST_IDLE;
          end
        end
      end
      default: state_d = ST_IDLE;
    endcase
    // Output stage: strobe held while full, dropped once the word leaves.
    wr_d   = load ? 1'b1 : (wr_q && txfifo_full);
    data_d = load ? load_data : data_q;
  end

  always_ff @(posedge sys_clk) begin
    if (sys_rst) begin
      state_q <= ST_IDLE;
      grant_q <= '0;
      last_q  <= ID_W'(N_REQ - 1);
      cnt_q   <= '0;
      wr_q    <= 1'b0;
      data_q  <= '0;
      trunc_q <= 1'b0;
    end else begin
      state_q <= state_d;
      grant_q <= grant_d;
      last_q  <= last_d;
      cnt_q   <= cnt_d;
      wr_q    <= wr_d;
      data_q  <= data_d;
      trunc_q <= trunc_d;
    end
  end

  assign txfifo_wr   = wr_q;
  assign txfifo_data = data_q;
  assign grant_id    = grant_q;
  assign busy        = (state_q != ST_IDLE);
  assign trunc_pulse = trunc_q;

endmodule

// File: tb/tb_ft_txfifo_arbiter.sv
// Self-checking bench for ft_txfifo_arbiter: arbitration vector table plus
// scoreboarded packet scenarios (stall, truncation, mid-stream reset).
module tb_ft_txfifo_arbiter;

  localparam int unsigned DW  = 8;
  localparam int unsigned NR  = 3;
  localparam int unsigned MPL = 4;

  logic              sys_clk = 1'b0;
  logic              sys_rst = 1'b1;
  logic [NR-1:0]     req_valid = '0;
  logic [NR*DW-1:0]  req_data = '0;
  logic [NR-1:0]     req_last = '0;
  logic [NR-1:0]     req_ready;
  logic [DW-1:0]     txfifo_data;
  logic              txfifo_wr;
  logic              txfifo_full = 1'b0;
  logic [3:0]        grant_id;
  logic              busy;
  logic              trunc_pulse;

  ft_txfifo_arbiter #(.DATA_W(DW), .N_REQ(NR), .MAX_PKT_LEN(MPL)) dut (
    .sys_clk(sys_clk), .sys_rst(sys_rst),
    .req_valid(req_valid), .req_data(req_data), .req_last(req_last),
    .req_ready(req_ready),
    .txfifo_data(txfifo_data), .txfifo_wr(txfifo_wr), .txfifo_full(txfifo_full),
    .grant_id(grant_id), .busy(busy), .trunc_pulse(trunc_pulse)
  );

  always #5 sys_clk = ~sys_clk;

  int errors = 0;
  int checks = 0;
  int cyc = 0;
  int full_from = 0;
  int full_to = 0;
  int trunc_cnt = 0;
  logic [31:0] wr_hist = '0;
  logic [8:0] srcq [NR][$];
  logic [7:0] expq [$];

  typedef struct {
    logic [NR-1:0] mask;
    logic [3:0]    gid;
  } vec_t;
  vec_t vecs [10];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic drive();
    for (int s = 0; s < NR; s++) begin
      if (srcq[s].size() > 0) begin
        req_valid[s]          = 1'b1;
        req_data[s*DW +: DW]  = srcq[s][0][7:0];
        req_last[s]           = srcq[s][0][8];
      end else begin
        req_valid[s] = 1'b0;
        req_last[s]  = 1'b0;
      end
    end
    txfifo_full = (cyc + 1 >= full_from) && (cyc + 1 < full_to);
  endtask

  // One clock: monitor outputs at negedge, retire handshakes after posedge.
  task automatic step();
    logic [NR-1:0] hs;
    logic [7:0] e;
    cyc++;
    @(negedge sys_clk);
    if (txfifo_full && expq.size() > 0) begin
      chk("stall_wr", 32'(txfifo_wr), 32'd1);
      chk("stall_data", 32'(txfifo_data), 32'(expq[0]));
      chk("stall_ready", 32'(req_ready), 32'd0);
    end
    if (txfifo_wr && cyc < 32) wr_hist[cyc] = 1'b1;
    if (txfifo_wr && !txfifo_full) begin
      if (expq.size() == 0) begin
        chk("extra_word", 32'(txfifo_data), 32'hFFFF_FFFF);
      end else begin
        e = expq.pop_front();
        chk("stream", 32'(txfifo_data), 32'(e));
      end
    end
    if (trunc_pulse) trunc_cnt++;
    hs = req_valid & req_ready;
    @(posedge sys_clk);
    #1;
    for (int s = 0; s < NR; s++)
      if (hs[s] && srcq[s].size() > 0) void'(srcq[s].pop_front());
    drive();
  endtask

  task automatic do_reset();
    sys_rst     = 1'b1;
    req_valid   = '0;
    req_last    = '0;
    txfifo_full = 1'b0;
    full_from   = 0;
    full_to     = 0;
    @(posedge sys_clk);
    @(negedge sys_clk);
    chk("rst_wr", 32'(txfifo_wr), 32'd0);
    chk("rst_data", 32'(txfifo_data), 32'd0);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_grant", 32'(grant_id), 32'd0);
    chk("rst_ready", 32'(req_ready), 32'd0);
    chk("rst_trunc", 32'(trunc_pulse), 32'd0);
    @(posedge sys_clk);
    #1;
    sys_rst = 1'b0;
    for (int s = 0; s < NR; s++) srcq[s].delete();
    expq.delete();
    cyc = 0;
    trunc_cnt = 0;
    wr_hist = '0;
  endtask

  task automatic add_pkt(input int s, input logic [7:0] base, input int n, input bit with_last);
    for (int i = 0; i < n; i++)
      srcq[s].push_back({with_last && (i == n - 1), 8'(base + 8'(i))});
  endtask

  task automatic exp_seq(input logic [7:0] base, input int n);
    for (int i = 0; i < n; i++) expq.push_back(8'(base + 8'(i)));
  endtask

  task automatic run(input int budget);
    drive();
    while (expq.size() > 0 && cyc < budget) step();
    chk("drain_timeout", 32'(expq.size()), 32'd0);
    repeat (2) step();
    chk("busy_end", 32'(busy), 32'd0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    // mask -> expected grant, last_grant carried from the previous row
    vecs[0] = '{3'b111, 4'd0};
    vecs[1] = '{3'b111, 4'd1};
    vecs[2] = '{3'b111, 4'd2};
    vecs[3] = '{3'b101, 4'd0};
    vecs[4] = '{3'b110, 4'd1};
    vecs[5] = '{3'b001, 4'd0};
    vecs[6] = '{3'b100, 4'd2};
    vecs[7] = '{3'b011, 4'd0};
    vecs[8] = '{3'b010, 4'd1};
    vecs[9] = '{3'b101, 4'd2};

    do_reset();

    // Arbitration table: single-word packets, one per row.
    req_data = {8'h52, 8'h51, 8'h50};
    for (int i = 0; i < 10; i++) begin
      req_valid = vecs[i].mask;
      req_last  = '1;
      @(negedge sys_clk);
      chk("idle_ready", 32'(req_ready), 32'd0);
      @(negedge sys_clk);
      chk("tbl_grant", 32'(grant_id), 32'(vecs[i].gid));
      chk("tbl_busy", 32'(busy), 32'd1);
      chk("tbl_ready", 32'(req_ready), 32'd1 << vecs[i].gid);
      @(posedge sys_clk);
      #1;
      req_valid = '0;
      @(negedge sys_clk);
      chk("tbl_wr", 32'(txfifo_wr), 32'd1);
      chk("tbl_data", 32'(txfifo_data), 32'h50 + 32'(vecs[i].gid));
      chk("tbl_busy_end", 32'(busy), 32'd0);
      @(posedge sys_clk);
      #1;
    end

    // Single 4-word packet: strobe on cycles 3..6 after first valid.
    do_reset();
    add_pkt(0, 8'h10, 4, 1'b1);
    exp_seq(8'h10, 4);
    run(30);
    chk("latency_hist", wr_hist, 32'h78);

    // Three continuous requesters, 2-word packets, round-robin order.
    do_reset();
    for (int s = 0; s < NR; s++)
      for (int p = 0; p < 2; p++)
        add_pkt(s, 8'(8'h20 + 8'(s * 16 + p * 2)), 2, 1'b1);
    for (int p = 0; p < 2; p++)
      for (int s = 0; s < NR; s++)
        exp_seq(8'(8'h20 + 8'(s * 16 + p * 2)), 2);
    run(60);

    // FIFO full for 5 cycles mid-packet.
    do_reset();
    add_pkt(1, 8'h30, 8, 1'b1);
    exp_seq(8'h30, 8);
    full_from = 5;
    full_to   = 10;
    run(60);

    // Forced release after MAX_PKT_LEN words, requester 2 served in between.
    do_reset();
    add_pkt(1, 8'h40, 6, 1'b1);
    add_pkt(2, 8'h50, 2, 1'b1);
    exp_seq(8'h40, 4);
    exp_seq(8'h50, 2);
    exp_seq(8'h44, 2);
    run(60);
    chk("trunc_once", 32'(trunc_cnt), 32'd1);

    // Last word coincides with the limit: normal end, no truncation pulse.
    do_reset();
    add_pkt(0, 8'h60, 4, 1'b1);
    exp_seq(8'h60, 4);
    run(30);
    chk("no_trunc", 32'(trunc_cnt), 32'd0);

    // Reset while a word is stalled in the output stage.
    do_reset();
    add_pkt(1, 8'h70, 8, 1'b1);
    exp_seq(8'h70, 8);
    full_from = 4;
    full_to   = 1000;
    drive();
    while (cyc < 5) step();
    sys_rst = 1'b1;
    @(posedge sys_clk);
    @(negedge sys_clk);
    chk("mrst_wr", 32'(txfifo_wr), 32'd0);
    chk("mrst_busy", 32'(busy), 32'd0);
    chk("mrst_grant", 32'(grant_id), 32'd0);
    for (int s = 0; s < NR; s++) srcq[s].delete();
    expq.delete();
    full_from = 0;
    full_to   = 0;
    cyc       = 0;
    @(posedge sys_clk);
    #1;
    sys_rst = 1'b0;
    add_pkt(0, 8'h80, 1, 1'b1);
    add_pkt(1, 8'h81, 1, 1'b1);
    add_pkt(2, 8'h82, 1, 1'b1);
    exp_seq(8'h80, 3);
    run(40);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
